// File: rtl/nas_vid_pkg.sv
// nas_vid_pkg: shared types and constants for the NASCOM 1 video RAM arbiter.
package nas_vid_pkg;
  localparam int VRAM_AW = 10;
  localparam int VID_PERIOD = 8;
  localparam logic [15:0] CPU_BASE = 16'h0800;
  typedef enum logic [2:0] {IDLE, VID_RD, VID_CAP, CPU_RD, CPU_CAP, CPU_WR} arb_state_t;
endpackage

// File: rtl/nas_sync.sv
// nas_sync: N-flop synchroniser with asynchronous active-low reset.
module nas_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [N-1:0] s_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s_q <= '0;
    else begin
      s_q[0] <= d;
      for (int i = 1; i < N; i++) s_q[i] <= s_q[i-1];
    end
  end
  assign q = s_q[N-1];
endmodule

// File: rtl/nas_vram_arb.sv
// nas_vram_arb: shares the single-port VRAM between display fetches (always first)
// and CPU accesses, which are stalled through cpu_wait_n.
module nas_vram_arb import nas_vid_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int AW = VRAM_AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_data,
  output logic          vid_ack,
  output logic          vid_ovf,
  input  logic          vdusel_n,
  input  logic          rd_n,
  input  logic          wr_n,
  input  logic [AW-1:0] cpu_a,
  input  logic [7:0]    cpu_di,
  output logic [7:0]    cpu_do,
  output logic          cpu_wait_n,
  output logic [AW-1:0] ram_a,
  output logic [7:0]    ram_wd,
  input  logic [7:0]    ram_rd,
  output logic          ram_ce,
  output logic          ram_we
);
  arb_state_t state_q, state_d;
  logic strb_s, strb_prev_q, cpu_start, idle, vid_go;
  logic cpu_pend_q, cpu_we_q, vid_pend_q;
  logic [AW-1:0] cpu_a_q, vid_addr_q, ram_a_q;
  logic [7:0] cpu_di_q, vid_data_q, cpu_do_q, ram_wd_q;
  logic vid_ack_q, vid_ovf_q, cpu_wait_n_q, ram_ce_q, ram_we_q;

  nas_sync #(.N(SYNC_STAGES)) u_sync (
    .clk(clk), .reset_n(reset_n), .d(~vdusel_n & (~rd_n | ~wr_n)), .q(strb_s)
  );

  assign cpu_start = strb_s & ~strb_prev_q;
  assign idle = state_q == IDLE;
  assign vid_go = idle & (vid_req | vid_pend_q);

  always_comb begin
    state_d = IDLE;
    state_d = idle ? (vid_go ? VID_RD : cpu_pend_q ? (cpu_we_q ? CPU_WR : CPU_RD) : IDLE)
            : state_q == VID_RD ? VID_CAP
            : state_q == CPU_RD ? CPU_CAP
            : IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      strb_prev_q <= 1'b0;
      cpu_pend_q <= 1'b0;
      cpu_we_q <= 1'b0;
      cpu_a_q <= '0;
      cpu_di_q <= '0;
      vid_pend_q <= 1'b0;
      vid_addr_q <= '0;
      vid_data_q <= '0;
      vid_ack_q <= 1'b0;
      vid_ovf_q <= 1'b0;
      cpu_do_q <= '0;
      cpu_wait_n_q <= 1'b1;
      ram_a_q <= '0;
      ram_wd_q <= '0;
      ram_ce_q <= 1'b0;
      ram_we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      strb_prev_q <= strb_s;
      vid_ack_q <= state_q == VID_CAP;
      if (state_q == VID_CAP) vid_data_q <= ram_rd;
      if (state_q == CPU_CAP) cpu_do_q <= ram_rd;
      // An idle FSM consumes the pending fetch, so a same-cycle request becomes the new pending one
      vid_pend_q <= idle ? (vid_pend_q & vid_req) : (vid_pend_q | vid_req);
      if (vid_req && (vid_pend_q == idle)) vid_addr_q <= vid_addr;
      if (vid_req && vid_pend_q && !idle) vid_ovf_q <= 1'b1;
      if (cpu_start) begin
        cpu_pend_q <= 1'b1;
        cpu_wait_n_q <= 1'b0;
        cpu_a_q <= cpu_a;
        cpu_di_q <= cpu_di;
        cpu_we_q <= ~wr_n;
      end else if (state_q == CPU_CAP || state_q == CPU_WR) begin
        cpu_pend_q <= 1'b0;
        cpu_wait_n_q <= 1'b1;
      end
      ram_ce_q <= state_d inside {VID_RD, CPU_RD, CPU_WR};
      ram_we_q <= state_d == CPU_WR;
      if (state_d == VID_RD) ram_a_q <= vid_pend_q ? vid_addr_q : vid_addr;
      if (state_d == CPU_RD || state_d == CPU_WR) ram_a_q <= cpu_a_q;
      if (state_d == CPU_WR) ram_wd_q <= cpu_di_q;
    end
  end

  assign vid_data = vid_data_q;
  assign vid_ack = vid_ack_q;
  assign vid_ovf = vid_ovf_q;
  assign cpu_do = cpu_do_q;
  assign cpu_wait_n = cpu_wait_n_q;
  assign ram_a = ram_a_q;
  assign ram_wd = ram_wd_q;
  assign ram_ce = ram_ce_q;
  assign ram_we = ram_we_q;
endmodule

// File: tb/tb_nas_vram_arb.sv
// tb_nas_vram_arb: randomized scoreboard bench; expected fetches and CPU completions
// are queued at issue time and matched by a negedge monitor.
module tb_nas_vram_arb;
  logic clk = 1'b0, reset_n = 1'b0;
  logic vid_req = 1'b0;
  logic [9:0] vid_addr = '0, cpu_a = '0, ram_a;
  logic [7:0] cpu_di = '0, vid_data, cpu_do, ram_wd, ram_rd = '0;
  logic vid_ack, vid_ovf, cpu_wait_n, ram_ce, ram_we;
  logic vdusel_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;

  nas_vram_arb dut (
    .clk(clk), .reset_n(reset_n), .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_data(vid_data), .vid_ack(vid_ack), .vid_ovf(vid_ovf),
    .vdusel_n(vdusel_n), .rd_n(rd_n), .wr_n(wr_n), .cpu_a(cpu_a), .cpu_di(cpu_di),
    .cpu_do(cpu_do), .cpu_wait_n(cpu_wait_n), .ram_a(ram_a), .ram_wd(ram_wd),
    .ram_rd(ram_rd), .ram_ce(ram_ce), .ram_we(ram_we)
  );

  always #5 clk = ~clk;

  typedef struct {int cmin; int cmax; logic [7:0] d;} vexp_t;
  typedef struct {bit rd; logic [7:0] d; int lmin; int lmax;} cexp_t;
  vexp_t vq[$];
  cexp_t cq[$];
  vexp_t mv;
  cexp_t mc;
  logic [7:0] mem [1024];
  logic [7:0] ref_mem [1024];
  int cyc = 0, n_tests = 0, n_fail = 0, n_acc = 0, n_wr = 0, wrun = 0;
  logic [9:0] last_wa = '0;
  logic [7:0] last_wd = '0;

  initial for (int i = 0; i < 1024; i++) begin
    mem[i] = i[7:0];
    ref_mem[i] = i[7:0];
  end

  // Synchronous VRAM macro: read data valid the cycle after ce
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_ce) begin
      ram_rd <= mem[ram_a];
      n_acc <= n_acc + 1;
      if (ram_we) begin
        mem[ram_a] <= ram_wd;
        n_wr <= n_wr + 1;
        last_wa <= ram_a;
        last_wd <= ram_wd;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_vid_data"}, vid_data, 0);
    chk({p, "_vid_ack"}, vid_ack, 0);
    chk({p, "_vid_ovf"}, vid_ovf, 0);
    chk({p, "_cpu_do"}, cpu_do, 0);
    chk({p, "_cpu_wait_n"}, cpu_wait_n, 1);
    chk({p, "_ram_a"}, ram_a, 0);
    chk({p, "_ram_wd"}, ram_wd, 0);
    chk({p, "_ram_ce"}, ram_ce, 0);
    chk({p, "_ram_we"}, ram_we, 0);
  endtask

  always @(negedge clk) begin
    if (!reset_n) wrun = 0;
    else begin
      if (vid_ack) begin
        if (vq.size() == 0) chk("vid_ack_unexpected", 1, 0);
        else begin
          mv = vq.pop_front();
          chk("vid_data", vid_data, mv.d);
          chk_rng("vid_ack_cycle", cyc, mv.cmin, mv.cmax);
        end
      end
      if (!cpu_wait_n) wrun++;
      else if (wrun > 0) begin
        if (cq.size() == 0) chk("cpu_wait_unexpected", 1, 0);
        else begin
          mc = cq.pop_front();
          chk_rng("cpu_wait_len", wrun, mc.lmin, mc.lmax);
          if (mc.rd) chk("cpu_do", cpu_do, mc.d);
        end
        wrun = 0;
      end
    end
  end

  // Call on a negedge; ack is expected lo..hi cycles after the request cycle
  task automatic vid_pulse(input logic [9:0] a, input int lo, input int hi);
    vexp_t e;
    e.cmin = cyc + lo;
    e.cmax = cyc + hi;
    e.d = ref_mem[a];
    vq.push_back(e);
    vid_req = 1'b1;
    vid_addr = a;
    @(negedge clk);
    vid_req = 1'b0;
  endtask

  task automatic cpu_op(input bit we, input logic [9:0] a, input logic [7:0] d,
                        input int hold, input int lmin, input int lmax);
    cexp_t e;
    int t;
    e.rd = !we;
    e.d = ref_mem[a];
    e.lmin = lmin;
    e.lmax = lmax;
    if (we) ref_mem[a] = d;
    cq.push_back(e);
    @(negedge clk);
    cpu_a = a;
    cpu_di = d;
    vdusel_n = 1'b0;
    rd_n = we;
    wr_n = !we;
    t = 0;
    while (cpu_wait_n && t < 20) begin @(negedge clk); t++; end
    while (!cpu_wait_n && t < 40) begin @(negedge clk); t++; end
    chk("cpu_handshake_timeout", t < 40, 1);
    repeat (hold) @(negedge clk);
    vdusel_n = 1'b1;
    rd_n = 1'b1;
    wr_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] a;
    vexp_t e;
    int acc0, wr0, t;
    repeat (3) @(negedge clk);
    chk_rst("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    // video only, including both address boundaries
    for (int i = 0; i < 24; i++) begin
      a = (i == 0) ? 10'h000 : (i == 1) ? 10'h3FF : 10'($urandom);
      vid_pulse(a, 3, 3);
      repeat (7) @(negedge clk);
    end
    chk("vid_ovf_video_only", vid_ovf, 0);
    // CPU write then read
    wr0 = n_wr;
    cpu_op(1'b1, 10'h123, 8'hA5, 0, 2, 2);
    chk("wr_count", n_wr - wr0, 1);
    chk("wr_addr", last_wa, 10'h123);
    chk("wr_data", last_wd, 8'hA5);
    chk("wr_mem", mem[10'h123], 8'hA5);
    cpu_op(1'b0, 10'h123, 8'h00, 0, 3, 3);
    // collision: vid_req in the same cycle as cpu_start
    fork
      cpu_op(1'b0, 10'h123, 8'h00, 0, 3, 6);
      begin
        repeat (3) @(negedge clk);
        vid_pulse(10'($urandom_range(0, 511)), 3, 3);
      end
    join
    repeat (4) @(negedge clk);
    // mixed random traffic at the nominal fetch rate
    fork
      for (int i = 0; i < 16; i++) begin
        vid_pulse(10'($urandom_range(0, 511)), 3, 5);
        repeat (7) @(negedge clk);
      end
      for (int i = 0; i < 10; i++) begin
        cpu_op(1'($urandom), 10'($urandom_range(512, 1023)), 8'($urandom),
               $urandom_range(0, 3), 2, 6);
        repeat ($urandom_range(0, 5)) @(negedge clk);
      end
    join
    repeat (10) @(negedge clk);
    chk("vid_ovf_mixed", vid_ovf, 0);
    // strobe held for ~40 cycles triggers one access only
    acc0 = n_acc;
    cpu_op(1'b0, 10'h2F0, 8'h00, 34, 3, 3);
    chk("held_strobe_accesses", n_acc - acc0, 1);
    // overflow: three back-to-back requests, third dropped
    for (int k = 0; k < 3; k++) begin
      a = 10'($urandom_range(0, 511));
      vid_req = 1'b1;
      vid_addr = a;
      if (k < 2) begin
        e.cmin = cyc + (k == 0 ? 3 : 5);
        e.cmax = e.cmin;
        e.d = ref_mem[a];
        vq.push_back(e);
      end
      @(negedge clk);
    end
    vid_req = 1'b0;
    repeat (10) @(negedge clk);
    chk("ovf_set", vid_ovf, 1);
    chk("ovf_drained", vq.size(), 0);
    repeat (20) @(negedge clk);
    chk("ovf_sticky", vid_ovf, 1);
    // reset in the middle of a CPU write
    cpu_a = 10'h055;
    cpu_di = 8'h3C;
    vdusel_n = 1'b0;
    wr_n = 1'b0;
    t = 0;
    while (!ram_we && t < 20) begin @(negedge clk); t++; end
    chk("rstwr_reached_write", ram_we, 1);
    #1 reset_n = 1'b0;
    #1;
    chk_rst("rstwr");
    @(negedge clk);
    chk("rstwr_mem_untouched", mem[10'h055], ref_mem[10'h055]);
    vdusel_n = 1'b1;
    wr_n = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    vid_pulse(10'h3FF, 3, 3);
    repeat (10) @(negedge clk);
    chk("final_vq_empty", vq.size(), 0);
    chk("final_cq_empty", cq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
